// File: rtl/nucleic_acid_sequencer_pkg.sv
// Shared definitions for the nucleic-acid extraction sequencer.
// Holds the step encoding, the per-step open-set valve vectors and the
// peristaltic pump pattern ROM.
// Valve vector bit order (MSB..LSB): lysis, wash, elute, horiz, vertical,
// dead_end, loop_exit, bead_vtl, bead_trap, collection.
// In an open-set vector a 1 means "open". The pins carry the inverse, because
// a pin value of 1 applies air and so closes the valve.
package mfda_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LYSE  = 3'd1,
        ST_BEAD  = 3'd2,
        ST_MIX   = 3'd3,
        ST_TRAP  = 3'd4,
        ST_WASH  = 3'd5,
        ST_ELUTE = 3'd6,
        ST_DONE  = 3'd7
    } seq_state_e;

    localparam logic [9:0] VALVES_CLOSED = 10'b11_1111_1111;
    localparam logic [2:0] PUMPS_CLOSED  = 3'b111;

    localparam logic [9:0] OPEN_LYSE  = 10'b10_0010_0000; // lysis, vertical
    localparam logic [9:0] OPEN_BEAD  = 10'b00_0100_0100; // horiz, bead_vtl
    localparam logic [9:0] OPEN_MIX   = 10'b00_0000_0000; // pumps only
    localparam logic [9:0] OPEN_TRAP  = 10'b01_0001_1000; // wash (waste), dead_end, loop_exit
    localparam logic [9:0] OPEN_WASH  = 10'b01_0010_0000; // wash, vertical
    localparam logic [9:0] OPEN_ELUTE = 10'b00_1010_0011; // elute, vertical, bead_trap, collection

    // Pattern order is {pump1, pump2, pump3}.
    localparam logic [2:0] PUMP_ROM [0:5] = '{3'b011, 3'b001, 3'b101,
                                              3'b100, 3'b110, 3'b010};

    // Open-set lookup. IDLE and DONE have no open valves.
    function automatic logic [9:0] open_set(input seq_state_e st);
        logic [9:0] v;
        case (st)
            ST_LYSE:  v = OPEN_LYSE;
            ST_BEAD:  v = OPEN_BEAD;
            ST_MIX:   v = OPEN_MIX;
            ST_TRAP:  v = OPEN_TRAP;
            ST_WASH:  v = OPEN_WASH;
            ST_ELUTE: v = OPEN_ELUTE;
            default:  v = 10'b00_0000_0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/nucleic_acid_sequencer_pump_drv.sv
// Peristaltic pump driver: steps through the 6-phase pump pattern, one phase
// every PUMP_DIV enabled cycles. The output is registered, so the pattern
// entry chosen while en is high appears on the following cycle. When en is low
// the output is all-closed.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the pattern and drive it on the next cycle
//   clr        : return the prescaler and the phase to zero
//   pumps      : registered {pump1, pump2, pump3}
module peristaltic_pump_drv
    import mfda_seq_pkg::*;
#(
    parameter int unsigned PUMP_DIV = 10,
    parameter int unsigned TW       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [2:0] pumps
);

    localparam logic [TW-1:0] DIV_LAST = TW'(PUMP_DIV - 1);

    logic [TW-1:0] div_r;
    logic [2:0]    phase_r;

    // Prescaler, phase counter (modulo 6) and registered pattern output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r   <= {TW{1'b0}};
            phase_r <= 3'd0;
            pumps   <= PUMPS_CLOSED;
        end else if (clr) begin
            div_r   <= {TW{1'b0}};
            phase_r <= 3'd0;
            pumps   <= PUMPS_CLOSED;
        end else if (en) begin
            pumps <= PUMP_ROM[phase_r];
            if (div_r == DIV_LAST) begin
                div_r   <= {TW{1'b0}};
                phase_r <= (phase_r == 3'd5) ? 3'd0 : phase_r + 3'd1;
            end else begin
                div_r <= div_r + {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            pumps <= PUMPS_CLOSED;
        end
    end

endmodule

// File: rtl/nucleic_acid_sequencer.sv
// Pneumatic step sequencer for the 11-lane extraction array. It runs
// LYSE, BEAD, MIX, TRAP, WASH and ELUTE in order, then DONE. Each step is
// preceded by an all-closed guard. Every output is registered: the next-cycle
// values are decoded from the next state and then registered.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : level-sampled run request, honoured only in IDLE
//   abort        : return to IDLE with all valves closed (highest priority)
//   busy, done   : status; done is a one-cycle pulse on completion
//   state        : current step encoding
//   *_ctl        : valve lines (1 = closed)
//   pump1..pump3 : peristaltic pump valve lines (1 = closed)
module nucleic_acid_sequencer
    import mfda_seq_pkg::*;
#(
    parameter int unsigned LOAD_CYC  = 200,
    parameter int unsigned TRAP_CYC  = 100,
    parameter int unsigned WASH_CYC  = 300,
    parameter int unsigned ELUTE_CYC = 300,
    parameter int unsigned PUMP_DIV  = 10,
    parameter int unsigned MIX_ROT   = 20,
    parameter int unsigned GUARD_CYC = 2,
    parameter int unsigned TW        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [2:0] state,
    output logic       lysis_ctl,
    output logic       wash_ctl,
    output logic       elute_ctl,
    output logic       horiz_ctl,
    output logic       vertical_ctl,
    output logic       dead_end_ctl,
    output logic       loop_exit_ctl,
    output logic       bead_vtl_ctl,
    output logic       bead_trap_ctl,
    output logic       collection_ctl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3
);

    localparam bit            HAS_GUARD = (GUARD_CYC != 0);
    // This value is only loaded when HAS_GUARD is set.
    localparam logic [TW-1:0] GUARD_M1  = TW'(GUARD_CYC - 1);

    // Timer reload value (duration minus one) for each step's open phase.
    function automatic logic [TW-1:0] dur_m1(input seq_state_e st);
        logic [TW-1:0] d;
        case (st)
            ST_LYSE, ST_BEAD: d = TW'(LOAD_CYC - 1);
            ST_MIX:           d = TW'(6 * MIX_ROT * PUMP_DIV - 1);
            ST_TRAP:          d = TW'(TRAP_CYC - 1);
            ST_WASH:          d = TW'(WASH_CYC - 1);
            ST_ELUTE:         d = TW'(ELUTE_CYC - 1);
            default:          d = {TW{1'b0}};
        endcase
        return d;
    endfunction

    seq_state_e    state_r, state_n;
    logic          guard_r, guard_n;
    logic [TW-1:0] timer_r, timer_n;
    logic          enter_s;

    logic [9:0]    valves_n, valves_r;
    logic          busy_n, busy_r;
    logic          done_n, done_r;
    logic          mix_open_n;
    logic [2:0]    pumps_s;

    // State register: step, guard flag and down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            guard_r <= 1'b0;
            timer_r <= {TW{1'b0}};
        end else begin
            state_r <= state_n;
            guard_r <= guard_n;
            timer_r <= timer_n;
        end
    end

    // Next-state logic. Abort overrides start and every timer expiry.
    always_comb begin
        state_n = state_r;
        guard_n = guard_r;
        timer_n = timer_r;
        enter_s = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            guard_n = 1'b0;
            timer_n = {TW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_n = ST_LYSE;
                        enter_s = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    if (timer_r != {TW{1'b0}}) begin
                        timer_n = timer_r - {{(TW-1){1'b0}}, 1'b1};
                    end else if (guard_r) begin
                        guard_n = 1'b0;
                        timer_n = dur_m1(state_r);
                    end else if (state_r == ST_ELUTE) begin
                        state_n = ST_DONE;
                        guard_n = 1'b0;
                        timer_n = {TW{1'b0}};
                    end else begin
                        state_n = seq_state_e'(state_r + 3'd1);
                        enter_s = 1'b1;
                    end
                end
            endcase
            // Entering a step starts its guard; without a guard the open phase starts at once.
            if (enter_s) begin
                guard_n = HAS_GUARD;
                timer_n = HAS_GUARD ? GUARD_M1 : dur_m1(state_n);
            end else begin
                guard_n = guard_n;
            end
        end
    end

    // Output decode from the next state, so that the registered outputs line up with state_r.
    always_comb begin
        busy_n     = (state_n != ST_IDLE);
        done_n     = (state_n == ST_DONE);
        mix_open_n = (state_n == ST_MIX) && !guard_n;
        if (guard_n || state_n == ST_IDLE || state_n == ST_DONE) begin
            valves_n = VALVES_CLOSED;
        end else begin
            valves_n = ~open_set(state_n);
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valves_r <= VALVES_CLOSED;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            valves_r <= valves_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
        end
    end

    peristaltic_pump_drv #(
        .PUMP_DIV (PUMP_DIV),
        .TW       (TW)
    ) u_pump (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mix_open_n),
        .clr   (!mix_open_n),
        .pumps (pumps_s)
    );

    assign state = state_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
            dead_end_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl,
            collection_ctl} = valves_r;
    assign {pump1, pump2, pump3} = pumps_s;

endmodule
